// File: rtl/round_robin_dispatcher_if.sv
// round_robin_dispatcher_if: input stream plus per-lane output bundle for round_robin_dispatcher
interface round_robin_dispatcher_if #(
  parameter int NUM_OUT    = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int IW = $clog2(NUM_OUT);
  logic                  flush_i;
  logic [NUM_OUT-1:0]    enable_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [NUM_OUT-1:0]    valid_o;
  logic [NUM_OUT-1:0]    ready_i;
  logic [IW-1:0]         index_o;
  modport slave (
    input  flush_i, enable_i, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, index_o
  );
  modport master (
    output flush_i, enable_i, data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, index_o
  );
endinterface

// File: rtl/round_robin_dispatcher.sv
// round_robin_dispatcher: one-entry holding stage that hands each item to the next enabled lane in rotation
module round_robin_dispatcher #(
  parameter int NUM_OUT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  round_robin_dispatcher_if.slave bus
);
  localparam int IW = $clog2(NUM_OUT);
  typedef enum logic {EMPTY, OFFER} state_e;
  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IW-1:0]         r_target;
  logic [IW-1:0]         r_ptr;
  logic                  w_full;
  logic                  w_out_fire;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic [IW-1:0]         w_tgt_inc;
  logic [IW-1:0]         w_p_eff;
  logic [IW-1:0]         w_sel;
  // Scan downward so the last hit is the first enabled lane at or after p.
  function automatic logic [IW-1:0] sel(input logic [IW-1:0] p, input logic [NUM_OUT-1:0] en);
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    int            i;
    r = p;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      i = int'(p) + k;
      i = (i >= NUM_OUT) ? i - NUM_OUT : i;
      c = IW'(i);
      r = en[c] ? c : r;
    end
    return r;
  endfunction
  always_comb begin
    w_full      = (r_state == OFFER);
    w_out_fire  = w_full & bus.ready_i[r_target];
    w_in_ready  = (|bus.enable_i) & (~w_full | w_out_fire) & ~bus.flush_i;
    w_in_fire   = bus.valid_i & w_in_ready;
    w_tgt_inc   = (r_target == IW'(NUM_OUT - 1)) ? '0 : r_target + 1'b1;
    w_p_eff     = w_out_fire ? w_tgt_inc : r_ptr;
    w_sel       = sel(w_p_eff, bus.enable_i);
    w_state_nxt = bus.flush_i ? EMPTY : w_in_fire ? OFFER : w_out_fire ? EMPTY : r_state;
    bus.ready_o = w_in_ready;
    bus.valid_o = w_full ? (NUM_OUT'(1) << r_target) : '0;
    bus.data_o  = r_data;
    bus.index_o = r_target;
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_data   <= '0;
      r_target <= '0;
      r_ptr    <= '0;
    end else begin
      if (w_out_fire) r_ptr <= w_tgt_inc;
      if (w_in_fire) begin
        r_data   <= bus.data_i;
        r_target <= w_sel;
      end
    end
  end
endmodule

// File: tb/tb_round_robin_dispatcher.sv
// tb_round_robin_dispatcher: directed vector table plus reset and 3-lane wrap sequences
module tb_round_robin_dispatcher;
  logic clk = 1'b0;
  logic arst_ni = 1'b0;
  always #5 clk = ~clk;
  round_robin_dispatcher_if #(.NUM_OUT(4), .DATA_WIDTH(64)) bus ();
  round_robin_dispatcher_if #(.NUM_OUT(3), .DATA_WIDTH(8))  bus3 ();
  round_robin_dispatcher #(.NUM_OUT(4), .DATA_WIDTH(64)) dut (.clk_i(clk), .arst_ni(arst_ni), .bus(bus));
  round_robin_dispatcher #(.NUM_OUT(3), .DATA_WIDTH(8))  dut3 (.clk_i(clk), .arst_ni(arst_ni), .bus(bus3));
  typedef struct {
    logic        v;
    logic [3:0]  en;
    logic [3:0]  rdy;
    logic        fl;
    logic [7:0]  d;
    logic        ro;
    logic [3:0]  vo;
    logic [7:0]  dout;
    logic [1:0]  idx;
  } vec_t;
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  function automatic logic [63:0] wide(input logic [7:0] d);
    return {8'hA5, 48'h0, d};
  endfunction
  task automatic add(input logic v, input logic [3:0] en, input logic [3:0] rdy, input logic fl,
                     input logic [7:0] d, input logic ro, input logic [3:0] vo, input logic [7:0] dout,
                     input logic [1:0] idx);
    vecs.push_back('{v, en, rdy, fl, d, ro, vo, dout, idx});
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] en, input logic [3:0] rdy, input logic fl,
                       input logic [7:0] d);
    bus.valid_i  = v;
    bus.enable_i = en;
    bus.ready_i  = rdy;
    bus.flush_i  = fl;
    bus.data_i   = wide(d);
  endtask
  task automatic chk_out(input string tag, input logic [3:0] vo, input logic [63:0] dout, input logic [1:0] idx);
    chk({tag, " valid_o"}, 64'(bus.valid_o), 64'(vo));
    chk({tag, " data_o"}, bus.data_o, dout);
    chk({tag, " index_o"}, 64'(bus.index_o), 64'(idx));
  endtask
  initial begin
    // streaming, lanes 0..3 wrap
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h10, 1'b1, 4'h1, 8'h10, 2'd0);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h11, 1'b1, 4'h2, 8'h11, 2'd1);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h12, 1'b1, 4'h4, 8'h12, 2'd2);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h13, 1'b1, 4'h8, 8'h13, 2'd3);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h14, 1'b1, 4'h1, 8'h14, 2'd0);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h15, 1'b1, 4'h2, 8'h15, 2'd1);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h16, 1'b1, 4'h4, 8'h16, 2'd2);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h17, 1'b1, 4'h8, 8'h17, 2'd3);
    // masked lanes 1 and 3 only
    add(1'b1, 4'hA, 4'hF, 1'b0, 8'h20, 1'b1, 4'h2, 8'h20, 2'd1);
    add(1'b1, 4'hA, 4'hF, 1'b0, 8'h21, 1'b1, 4'h8, 8'h21, 2'd3);
    add(1'b1, 4'hA, 4'hF, 1'b0, 8'h22, 1'b1, 4'h2, 8'h22, 2'd1);
    add(1'b1, 4'hA, 4'hF, 1'b0, 8'h23, 1'b1, 4'h8, 8'h23, 2'd3);
    add(1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 4'h0, 8'h23, 2'd3);
    // stall on lane 2 for five cycles, then release
    add(1'b1, 4'h4, 4'hB, 1'b0, 8'h30, 1'b1, 4'h4, 8'h30, 2'd2);
    for (int i = 0; i < 5; i++) add(1'b1, 4'hF, 4'hB, 1'b0, 8'h31, 1'b0, 4'h4, 8'h30, 2'd2);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h31, 1'b1, 4'h8, 8'h31, 2'd3);
    add(1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 4'h0, 8'h31, 2'd3);
    // no lanes enabled backpressures input
    for (int i = 0; i < 3; i++) add(1'b1, 4'h0, 4'hF, 1'b0, 8'h40, 1'b0, 4'h0, 8'h31, 2'd3);
    add(1'b1, 4'h1, 4'hF, 1'b0, 8'h40, 1'b1, 4'h1, 8'h40, 2'd0);
    // flush while stalled keeps ptr; flush with out_fire advances it
    add(1'b1, 4'hF, 4'hD, 1'b0, 8'h50, 1'b1, 4'h2, 8'h50, 2'd1);
    add(1'b1, 4'hF, 4'hD, 1'b1, 8'h51, 1'b0, 4'h0, 8'h50, 2'd1);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h52, 1'b1, 4'h2, 8'h52, 2'd1);
    add(1'b1, 4'hF, 4'hF, 1'b1, 8'h53, 1'b0, 4'h0, 8'h52, 2'd1);
    add(1'b1, 4'hF, 4'hF, 1'b0, 8'h54, 1'b1, 4'h4, 8'h54, 2'd2);
    // held item still offered and served with its lane disabled
    add(1'b1, 4'h0, 4'h0, 1'b0, 8'h55, 1'b0, 4'h4, 8'h54, 2'd2);
    add(1'b1, 4'h0, 4'h4, 1'b0, 8'h55, 1'b0, 4'h0, 8'h54, 2'd2);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
    bus3.valid_i = 1'b0; bus3.enable_i = 3'b000; bus3.ready_i = 3'b000;
    bus3.flush_i = 1'b0; bus3.data_i = 8'h00;
    #1;
    chk_out("reset", 4'h0, 64'h0, 2'd0);
    chk("reset ready_o no lanes", 64'(bus.ready_o), 64'h0);
    bus.enable_i = 4'hF;
    #1;
    chk("reset ready_o", 64'(bus.ready_o), 64'h1);
    @(posedge clk); @(posedge clk);
    #3 arst_ni = 1'b1;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].rdy, vecs[i].fl, vecs[i].d);
      #1;
      chk($sformatf("v%0d ready_o", i), 64'(bus.ready_o), 64'(vecs[i].ro));
      @(posedge clk); #1;
      chk_out($sformatf("v%0d", i), vecs[i].vo, wide(vecs[i].dout), vecs[i].idx);
    end
    // asynchronous reset mid-offer; ptr is 3 here so the item lands on lane 3
    drive(1'b1, 4'hF, 4'h0, 1'b0, 8'h60);
    @(posedge clk); #1;
    chk_out("pre-reset", 4'h8, wide(8'h60), 2'd3);
    drive(1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    #2 arst_ni = 1'b0;
    #1;
    chk_out("async reset", 4'h0, 64'h0, 2'd0);
    @(posedge clk); #3 arst_ni = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 4'hF, 4'hF, 1'b0, 8'h61);
    @(posedge clk); #1;
    chk_out("after reset", 4'h1, wide(8'h61), 2'd0);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 8'h00);
    // three-lane instance wraps 0,1,2,0,1,2
    bus3.enable_i = 3'b111;
    bus3.ready_i  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      bus3.valid_i = 1'b1;
      bus3.data_i  = 8'(k + 1);
      #1;
      chk($sformatf("n3 step%0d ready_o", k), 64'(bus3.ready_o), 64'h1);
      @(posedge clk); #1;
      chk($sformatf("n3 step%0d index_o", k), 64'(bus3.index_o), 64'(k % 3));
      chk($sformatf("n3 step%0d valid_o", k), 64'(bus3.valid_o), 64'(3'b001 << (k % 3)));
      chk($sformatf("n3 step%0d data_o", k), 64'(bus3.data_o), 64'(k + 1));
    end
    bus3.valid_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
